// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller and the memory
// slave. The request channel uses valid/ready: the master raises
// Bus_Req_Valid and keeps every request field stable until a cycle in which
// Bus_Req_Ready is also high, and that cycle is the transfer. The response
// channel has no back-pressure: Bus_Rsp_Valid is a single-cycle strobe that
// the master must take in the cycle it is presented.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_ADDR_WIDTH = 32
);
  logic                      Bus_Req_Valid;
  logic                      Bus_Req_Ready;
  logic                      Bus_Req_We;
  logic [BUS_ADDR_WIDTH-1:0] Bus_Req_Addr;
  logic [DATA_WIDTH-1:0]     Bus_Req_WData;
  logic [3:0]                Bus_Req_Strb;
  logic                      Bus_Rsp_Valid;
  logic [DATA_WIDTH-1:0]     Bus_Rsp_RData;

  modport master (
    output Bus_Req_Valid,
    input  Bus_Req_Ready,
    output Bus_Req_We,
    output Bus_Req_Addr,
    output Bus_Req_WData,
    output Bus_Req_Strb,
    input  Bus_Rsp_Valid,
    input  Bus_Rsp_RData
  );

  modport slave (
    input  Bus_Req_Valid,
    output Bus_Req_Ready,
    input  Bus_Req_We,
    input  Bus_Req_Addr,
    input  Bus_Req_WData,
    input  Bus_Req_Strb,
    output Bus_Rsp_Valid,
    output Bus_Rsp_RData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Takes the load/store sitting in
// EX/MEM, issues one word-aligned request on the data bus, stalls the
// pipeline until the response (or a timeout) arrives, then aligns and
// extends the load data by funct3. Misaligned accesses never reach the bus.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      MEM_Mem_r,
  input  logic                      MEM_Mem_w,
  input  logic [BUS_ADDR_WIDTH-1:0] MEM_ALU_Result,
  input  logic [DATA_WIDTH-1:0]     MEM_Mem_W_Data,
  input  logic [3:0]                MEM_Mem_W_Strb,
  input  logic [2:0]                MEM_Funct3,
  mem_access_ctrl_if.master         bus,
  output logic                      Mem_Stall,
  output logic [DATA_WIDTH-1:0]     MEM_Load_Data,
  output logic                      Misalign_Err,
  output logic                      Bus_Err,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_lane;

  logic                  access;
  logic                  misaligned;
  logic [7:0]            rsp_byte;
  logic [15:0]           rsp_half;
  logic [DATA_WIDTH-1:0] load_next;

  assign access    = MEM_Mem_r | MEM_Mem_w;
  assign dbg_state = state;

  // Alignment rule depends only on the access size in funct3[1:0].
  always_comb begin
    misaligned = 1'b0;
    case (MEM_Funct3[1:0])
      2'b10:   misaligned = (MEM_ALU_Result[1:0] != 2'b00);
      2'b01:   misaligned = MEM_ALU_Result[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Stall covers the detect cycle in IDLE and every cycle the bus is busy;
  // DONE deliberately drops it so EX/MEM advances exactly once.
  always_comb begin
    Mem_Stall    = ((state == IDLE) && access && !misaligned) ||
                   (state == REQ) || (state == WAIT_RSP);
    Misalign_Err = (state == IDLE) && access && misaligned;
  end

  // Lane select and extension of the response using the captured funct3 and
  // the captured low address bits (the bus address itself is word-aligned).
  always_comb begin
    rsp_byte  = bus.Bus_Rsp_RData[{cap_lane, 3'b000} +: 8];
    rsp_half  = bus.Bus_Rsp_RData[{cap_lane[1], 4'b0000} +: 16];
    load_next = bus.Bus_Rsp_RData;
    case (cap_f3)
      3'b000:  load_next = {{(DATA_WIDTH-8){rsp_byte[7]}}, rsp_byte};
      3'b100:  load_next = {{(DATA_WIDTH-8){1'b0}}, rsp_byte};
      3'b001:  load_next = {{(DATA_WIDTH-16){rsp_half[15]}}, rsp_half};
      3'b101:  load_next = {{(DATA_WIDTH-16){1'b0}}, rsp_half};
      default: load_next = bus.Bus_Rsp_RData;
    endcase
  end

  // Access sequencer: request issue, response wait with timeout, one-cycle
  // completion. All bus request fields and the load result are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      cap_f3            <= 3'b000;
      cap_lane          <= 2'b00;
      bus.Bus_Req_Valid <= 1'b0;
      bus.Bus_Req_We    <= 1'b0;
      bus.Bus_Req_Addr  <= '0;
      bus.Bus_Req_WData <= '0;
      bus.Bus_Req_Strb  <= 4'b0000;
      MEM_Load_Data     <= '0;
      Bus_Err           <= 1'b0;
    end else begin
      Bus_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            // A load wins when both read and write are flagged.
            bus.Bus_Req_Valid <= 1'b1;
            bus.Bus_Req_We    <= MEM_Mem_w & ~MEM_Mem_r;
            bus.Bus_Req_Addr  <= {MEM_ALU_Result[BUS_ADDR_WIDTH-1:2], 2'b00};
            bus.Bus_Req_WData <= MEM_Mem_W_Data;
            bus.Bus_Req_Strb  <= MEM_Mem_r ? 4'b0000 : MEM_Mem_W_Strb;
            cap_f3            <= MEM_Funct3;
            cap_lane          <= MEM_ALU_Result[1:0];
            state             <= REQ;
          end
        end
        REQ: begin
          if (bus.Bus_Req_Ready) begin
            bus.Bus_Req_Valid <= 1'b0;
            cnt               <= '0;
            if (bus.Bus_Rsp_Valid) begin
              if (!bus.Bus_Req_We) MEM_Load_Data <= load_next;
              state <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.Bus_Rsp_Valid) begin
            if (!bus.Bus_Req_We) MEM_Load_Data <= load_next;
            cnt   <= '0;
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            MEM_Load_Data <= '0;
            Bus_Err       <= 1'b1;
            cnt           <= '0;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
